// File: rtl/dynamic_display_scan_ctrl.sv
// Scan controller for two 4-digit multiplexed 7-segment displays.
// Each frame has two parts. First, a one-cycle LOAD snapshots the source data.
// Then the four digits are visited in order, each with an optional blank phase
// followed by a drive phase.
// Optional build macro: DD_ZERO_SUPPRESS_EN blanks leading zero nibbles in hex mode.
module dynamic_display_scan_ctrl #(
    parameter int unsigned            COUNT_WIDTH  = 28,
    parameter logic [COUNT_WIDTH-1:0] SCAN_COUNT   = 28'h3000,
    parameter int unsigned            BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        ledCtrl,
    input  logic [31:0] cycleCount,
    input  logic [31:0] sortCount,
    input  logic [63:0] userSeg,
    output logic [15:0] ddSeg,
    output logic [7:0]  ddGate,
    output logic        frameTick
);

    localparam bit                     HAS_BLANK  = (BLANK_CYCLES != 0);
    localparam logic [COUNT_WIDTH-1:0] SCAN_LAST  = SCAN_COUNT - 1'b1;
    localparam logic [COUNT_WIDTH-1:0] BLANK_LAST =
        HAS_BLANK ? COUNT_WIDTH'(BLANK_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } state_t;

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [1:0]             r_digit;
    logic                   r_snap_mode;
    logic [15:0]            r_snap_cycle;
    logic [15:0]            r_snap_sort;
    logic [63:0]            r_snap_user;
    logic [15:0]            r_dd_seg;
    logic [7:0]             r_dd_gate;
    logic                   r_frame_tick;

    logic [15:0]            w_drive_seg;
    logic [7:0]             w_drive_gate;
    logic [3:0]             w_digit_gate;
    logic                   w_unused_hi;

    // Only the low halves of the counters are ever displayed.
    assign w_unused_hi = ^{cycleCount[31:16], sortCount[31:16]};

    // 7-segment pattern for one digit of one display, {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] seg_pattern(
        input logic        mode,
        input logic [15:0] val,
        input logic [31:0] user,
        input logic [1:0]  digit
    );
        logic [1:0]  digit_inv;
        logic [15:0] val_sh;
        logic [31:0] user_sh;
        logic [7:0]  pat;
        digit_inv = 2'd3 - digit;
        // Digit 0 is the leftmost, i.e. the most significant nibble / top user byte.
        val_sh    = val >> {digit_inv, 2'b00};
        user_sh   = user >> {digit_inv, 3'b000};
        if (mode) begin
            pat = user_sh[7:0];
        end else begin
            unique case (val_sh[3:0])
                4'h0: pat = 8'h3F;
                4'h1: pat = 8'h06;
                4'h2: pat = 8'h5B;
                4'h3: pat = 8'h4F;
                4'h4: pat = 8'h66;
                4'h5: pat = 8'h6D;
                4'h6: pat = 8'h7D;
                4'h7: pat = 8'h07;
                4'h8: pat = 8'h7F;
                4'h9: pat = 8'h6F;
                4'hA: pat = 8'h77;
                4'hB: pat = 8'h7C;
                4'hC: pat = 8'h39;
                4'hD: pat = 8'h5E;
                4'hE: pat = 8'h79;
                default: pat = 8'h71;
            endcase
`ifdef DD_ZERO_SUPPRESS_EN
            // All nibbles up to and including this one are zero -> leading zero.
            // The rightmost digit always shows, so a value of 0 reads as "0".
            if ((val_sh == 16'h0) && (digit != 2'd3)) begin
                pat = 8'h00;
            end
`endif
        end
        return pat;
    endfunction

    // Drive-phase segment and gate values for the current digit, from the snapshot.
    always_comb begin
        w_digit_gate = 4'b0001 << r_digit;
        w_drive_gate = {w_digit_gate, w_digit_gate};
        w_drive_seg  = {seg_pattern(r_snap_mode, r_snap_sort,  r_snap_user[63:32], r_digit),
                        seg_pattern(r_snap_mode, r_snap_cycle, r_snap_user[31:0],  r_digit)};
    end

    // Scan FSM; outputs are registered and reflect the state handled at each edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= StLoad;
            r_cnt        <= '0;
            r_digit      <= 2'd0;
            r_snap_mode  <= 1'b0;
            r_snap_cycle <= 16'h0;
            r_snap_sort  <= 16'h0;
            r_snap_user  <= 64'h0;
            r_dd_seg     <= 16'h0;
            r_dd_gate    <= 8'h0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            r_dd_seg     <= 16'h0;
            r_dd_gate    <= 8'h0;
            unique case (r_state)
                StLoad: begin
                    r_snap_mode  <= ledCtrl;
                    r_snap_cycle <= cycleCount[15:0];
                    r_snap_sort  <= sortCount[15:0];
                    r_snap_user  <= userSeg;
                    r_frame_tick <= 1'b1;
                    r_digit      <= 2'd0;
                    r_cnt        <= '0;
                    r_state      <= HAS_BLANK ? StBlank : StDrive;
                end
                StBlank: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt   <= '0;
                        r_state <= StDrive;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDrive: begin
                    r_dd_gate <= w_drive_gate;
                    r_dd_seg  <= w_drive_seg;
                    if (r_cnt == SCAN_LAST) begin
                        r_cnt <= '0;
                        if (r_digit == 2'd3) begin
                            r_state <= StLoad;
                        end else begin
                            r_digit <= r_digit + 1'b1;
                            r_state <= HAS_BLANK ? StBlank : StDrive;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StLoad;
                end
            endcase
        end
    end

    assign ddSeg     = r_dd_seg;
    assign ddGate    = r_dd_gate;
    assign frameTick = r_frame_tick;

endmodule

// File: tb/tb_dynamic_display_scan_ctrl.sv
// Self-checking bench for dynamic_display_scan_ctrl.
// Instance A: SCAN_COUNT=4, BLANK_CYCLES=1. Instance B: SCAN_COUNT=1, BLANK_CYCLES=0.
module tb_dynamic_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        ledCtrl;
    logic [31:0] cycleCount;
    logic [31:0] sortCount;
    logic [63:0] userSeg;
    logic [15:0] ddSeg_a, ddSeg_b;
    logic [7:0]  ddGate_a, ddGate_b;
    logic        frameTick_a, frameTick_b;

    always #5 clk = ~clk;

    dynamic_display_scan_ctrl #(
        .COUNT_WIDTH (8),
        .SCAN_COUNT  (8'd4),
        .BLANK_CYCLES(1)
    ) u_dut_a (
        .clk       (clk),
        .rstN      (rstN),
        .ledCtrl   (ledCtrl),
        .cycleCount(cycleCount),
        .sortCount (sortCount),
        .userSeg   (userSeg),
        .ddSeg     (ddSeg_a),
        .ddGate    (ddGate_a),
        .frameTick (frameTick_a)
    );

    dynamic_display_scan_ctrl #(
        .COUNT_WIDTH (8),
        .SCAN_COUNT  (8'd1),
        .BLANK_CYCLES(0)
    ) u_dut_b (
        .clk       (clk),
        .rstN      (rstN),
        .ledCtrl   (ledCtrl),
        .cycleCount(cycleCount),
        .sortCount (sortCount),
        .userSeg   (userSeg),
        .ddSeg     (ddSeg_b),
        .ddGate    (ddGate_b),
        .frameTick (frameTick_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    localparam logic [7:0] HEX_TAB [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Segment byte for display d, digit k, from a frame's captured data.
    function automatic logic [7:0] seg_of(input int d, input int k, input logic lc,
                                          input logic [15:0] cc, input logic [15:0] sc,
                                          input logic [63:0] us);
        logic [15:0] v;
        logic [15:0] sh;
        if (lc) return us[d*32 + 24 - 8*k +: 8];
        v  = (d == 0) ? cc : sc;
        sh = v >> (12 - 4*k);
`ifdef DD_ZERO_SUPPRESS_EN
        if (sh == 16'h0 && k < 3) return 8'h00;
`endif
        return HEX_TAB[sh[3:0]];
    endfunction

    // Expected {frameTick, ddGate, ddSeg} at frame position p.
    function automatic logic [24:0] model_out(input int p, input int s, input int b,
                                              input logic lc, input logic [15:0] cc,
                                              input logic [15:0] sc, input logic [63:0] us);
        int q, k, r;
        logic [3:0] g;
        if (p == 0) return {1'b1, 24'h0};
        q = p - 1;
        k = q / (b + s);
        r = q % (b + s);
        if (r < b) return 25'h0;
        g = 4'b0001 << k;
        return {1'b0, g, g, seg_of(1, k, lc, cc, sc, us), seg_of(0, k, lc, cc, sc, us)};
    endfunction

    // Model state: cycles since reset release plus the data captured at each frame start.
    int          na, nb;
    logic        ma_lc, mb_lc;
    logic [15:0] ma_cc, ma_sc, mb_cc, mb_sc;
    logic [63:0] ma_us, mb_us;
    logic [24:0] exp_a = '0, exp_b = '0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            na = 0; nb = 0; exp_a = '0; exp_b = '0;
        end else begin
            if (na % 21 == 0) begin
                ma_lc = ledCtrl; ma_cc = cycleCount[15:0]; ma_sc = sortCount[15:0]; ma_us = userSeg;
            end
            exp_a = model_out(na % 21, 4, 1, ma_lc, ma_cc, ma_sc, ma_us);
            na++;
            if (nb % 5 == 0) begin
                mb_lc = ledCtrl; mb_cc = cycleCount[15:0]; mb_sc = sortCount[15:0]; mb_us = userSeg;
            end
            exp_b = model_out(nb % 5, 1, 0, mb_lc, mb_cc, mb_sc, mb_us);
            nb++;
        end
    end

    // Per-cycle comparison against the model, plus gate exclusivity per display.
    always @(negedge clk) begin
        chk("A_out", {frameTick_a, ddGate_a, ddSeg_a}, exp_a);
        chk("B_out", {frameTick_b, ddGate_b, ddSeg_b}, exp_b);
        chk("A_onehot_d0", $countones(ddGate_a[3:0]) <= 1, 1);
        chk("A_onehot_d1", $countones(ddGate_a[7:4]) <= 1, 1);
        chk("B_onehot_d0", $countones(ddGate_b[3:0]) <= 1, 1);
        chk("B_onehot_d1", $countones(ddGate_b[7:4]) <= 1, 1);
    end

    task automatic wait_tick_a();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!frameTick_a && i < 200);
        if (!frameTick_a) chk("A_tick_timeout", frameTick_a, 1);
    endtask

    // Waits for a frame on A and checks each digit's first drive cycle.
    task automatic check_frame_a(input string tag, input logic [31:0] e0, input logic [31:0] e1);
        logic [3:0] g;
        wait_tick_a();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            g = 4'b0001 << k;
            chk({tag, "_gate"}, ddGate_a, {g, g});
            chk({tag, "_seg"}, ddSeg_a, {e1[31-8*k -: 8], e0[31-8*k -: 8]});
            if (k < 3) repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        logic [3:0] g;
        rstN       = 1'b0;
        ledCtrl    = 1'b0;
        cycleCount = 32'h0000_12AF;
        sortCount  = 32'h0000_0007;
        userSeg    = 64'h0;
        repeat (3) @(negedge clk);
        chk("reset_a", {frameTick_a, ddGate_a, ddSeg_a}, 0);
        chk("reset_b", {frameTick_b, ddGate_b, ddSeg_b}, 0);
        #2 rstN = 1'b1;

        // First clock after release is the LOAD cycle.
        @(negedge clk);
        chk("first_tick_a", frameTick_a, 1);

        // Frame period on A.
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frameTick_a && cnt < 50);
        chk("A_period", cnt, 21);

        // Frame period and gate rotation on B.
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frameTick_b && cnt < 20);
        chk("B_tick_seen", frameTick_b, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g = 4'b0001 << k;
            chk("B_rotate", ddGate_b, {g, g});
        end
        @(negedge clk);
        chk("B_period", frameTick_b, 1);

        // Hex mode.
`ifdef DD_ZERO_SUPPRESS_EN
        check_frame_a("hex", 32'h065B_7771, 32'h0000_0007);
`else
        check_frame_a("hex", 32'h065B_7771, 32'h3F3F_3F07);
`endif

        // User mode; ledCtrl changes mid-frame and only takes effect at the next LOAD.
        ledCtrl = 1'b1;
        userSeg = 64'h8040_2010_0804_0201;
        check_frame_a("user", 32'h0804_0201, 32'h8040_2010);

        // Tear-free: change cycleCount during digit 1 drive.
        ledCtrl    = 1'b0;
        cycleCount = 32'h0000_1111;
        sortCount  = 32'h0;
        wait_tick_a();
        repeat (2) @(negedge clk);
        chk("tear_d0", ddSeg_a[7:0], 8'h06);
        repeat (5) @(negedge clk);
        chk("tear_d1", ddSeg_a[7:0], 8'h06);
        cycleCount = 32'h0000_2222;
        repeat (5) @(negedge clk);
        chk("tear_d2", ddSeg_a[7:0], 8'h06);
        repeat (5) @(negedge clk);
        chk("tear_d3", ddSeg_a[7:0], 8'h06);
`ifdef DD_ZERO_SUPPRESS_EN
        check_frame_a("tear_next", 32'h5B5B_5B5B, 32'h0000_003F);
`else
        check_frame_a("tear_next", 32'h5B5B_5B5B, 32'h3F3F_3F3F);
`endif

        // Reset asserted during digit 2 drive.
        wait_tick_a();
        repeat (12) @(negedge clk);
        chk("mid_rst_pre_gate", ddGate_a, 8'h44);
        #2 rstN = 1'b0;
        #1;
        chk("mid_rst_a", {frameTick_a, ddGate_a, ddSeg_a}, 0);
        chk("mid_rst_b", {frameTick_b, ddGate_b, ddSeg_b}, 0);
        repeat (2) @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        chk("post_rst_tick", frameTick_a, 1);
        @(negedge clk);
        chk("post_rst_blank", ddGate_a, 8'h00);
        @(negedge clk);
        chk("post_rst_d0", ddGate_a, 8'h11);

        repeat (30) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
